coded_nibble_tx: RTL and testbench
==================================

Name: coded_nibble_tx

Overview:
- Serial framer directly downstream of the 4-bit code converter.
- Accepts one coded nibble {S3,S2,S1,S0} per valid/ready handshake and shifts it out LSB-first on a single line.
- Frame: start bit, data bits, optional even parity, stop bit(s).
- Feeds the board-level serial link; idle line is high.

Parameters:
- DATA_W, 4, width of the coded word per frame.
- CLKS_PER_BIT, 4, clock cycles per serial bit; legal range 2..255.
- STOP_BITS, 1, number of stop bits; legal values 1 or 2.

Ports:
- clk  input  1  rising-edge system clock.
- reset  input  1  reset, asynchronous, active-high.
- in_data  input  DATA_W  coded word; bit0 = S0, bit3 = S3.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  block can capture a word this cycle.
- tx_out  output  1  serial line; idle high.
- busy  output  1  a frame is in progress.
- frame_done  output  1  one-cycle pulse on the last cycle of the final stop bit.

Behaviour:
- Reset (async assert, release synchronous to clk):
  - tx_out=1, in_ready=1, busy=0, frame_done=0.
  - State=IDLE; shift register, bit counter and baud counter cleared.
- Capture:
  - A word is taken on the rising edge where in_valid && in_ready.
  - in_data is latched into the shift register; upstream may change in_data afterwards.
  - in_valid while in_ready=0 is ignored, not queued; upstream must hold the word.
  - X on in_data with in_valid=0 has no effect.
- State machine IDLE -> START -> DATA -> PARITY -> STOP -> IDLE:
  - IDLE: in_ready=1, busy=0, tx_out=1. On capture, go to START next cycle.
  - START: tx_out=0 for CLKS_PER_BIT cycles.
  - DATA: DATA_W bits, LSB first, each held CLKS_PER_BIT cycles. Bit counter runs 0..DATA_W-1.
  - PARITY: tx_out = XOR of captured bits (even parity) for CLKS_PER_BIT cycles. Present only with the optional feature.
  - STOP: tx_out=1 for STOP_BITS*CLKS_PER_BIT cycles. frame_done pulses on the final cycle; next state is IDLE.
- in_ready=0 and busy=1 in every state except IDLE.
- Latency:
  - tx_out falls on the cycle after capture.
  - Frame length is (1+DATA_W+P+STOP_BITS)*CLKS_PER_BIT cycles, with P=1 if parity is enabled, else 0.
  - Minimum capture-to-capture spacing is frame length + 1 (one IDLE cycle).
- Baud counter:
  - Counts 0..CLKS_PER_BIT-1 and wraps.
  - The bit advances on the wrap cycle.
  - Width is $clog2(CLKS_PER_BIT).
- Boundaries:
  - reset mid-frame: tx_out goes to 1 immediately (asynchronous); the partial frame is abandoned and frame_done is not pulsed.
  - in_valid held high continuously: the next word is captured in the IDLE cycle after frame_done.
  - in_data all zeros or all ones: transmitted normally, with no special encoding.

Optional Feature:
- Macro CODE_TX_PARITY_EN.
- Defined: PARITY state is included and one even-parity bit follows the data bits.
- Undefined: DATA goes straight to STOP and the frame is shorter by CLKS_PER_BIT cycles.
- All other timing and ports are identical in both builds.

Decomposition:
- Shared package code_link_pkg:
  - State enum (IDLE, START, DATA, PARITY, STOP).
  - Constant CODE_W=4.
  - Line level constants LINE_IDLE=1 and LINE_START=0.
  - Function computing frame length from the parameters, shared with the bench.
- One natural sub-module, baud_tick_gen:
  - Parameter CLKS_PER_BIT; inputs clk, reset, enable.
  - Produces a one-cycle tick on counter wrap.
  - Counter clears whenever enable=0.

Test Plan (CLKS_PER_BIT=4, STOP_BITS=1, parity enabled unless stated):
1. Release reset with no in_valid for 10 cycles -> tx_out=1, in_ready=1, busy=0, frame_done never asserted.
2. Send in_data=4'b1011 -> tx_out is 0,1,1,0,1,1(parity),1, each bit held 4 cycles. busy=1 for 28 cycles; frame_done on cycle 28; in_ready=1 on cycle 29.
3. Hold in_valid high with 4'b0000 then 4'b1111 -> second capture exactly 29 cycles after the first. Parity bits are 0 and 0. No word is lost or duplicated.
4. Assert reset during the second data bit of 4'b0110 -> tx_out=1 in the same timestep. After release, in_ready=1 and frame_done=0. A new word 4'b0001 then frames correctly.
5. Build without CODE_TX_PARITY_EN and send 4'b1011 -> frame is 24 cycles with no parity bit; frame_done on cycle 24.
6. Pulse in_valid with 4'b0101 mid-frame (in_ready=0) -> ignored; the frame in progress completes unchanged and no extra frame follows.

Source files
------------

// File: rtl/code_link_pkg.sv
// Shared definitions for the coded-nibble serial link: frame states,
// line levels and the frame-length helper used by the framer and its bench.
package code_link_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } code_state_e;

    localparam int   CODE_W     = 4;
    localparam logic LINE_IDLE  = 1'b1;
    localparam logic LINE_START = 1'b0;

    function automatic int frame_len(input int data_w, input int clks_per_bit,
                                     input int stop_bits, input int parity_bits);
        return (1 + data_w + parity_bits + stop_bits) * clks_per_bit;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled and flags the wrap
// cycle (tick) and the cycle before it (pre_tick); held at zero when disabled.
module baud_tick_gen #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    output logic tick,
    output logic pre_tick
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(CLKS_PER_BIT - 2);

    logic [CNT_W-1:0] cnt_r;

    // Free-running bit-period counter, cleared whenever the framer is idle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (!enable) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (cnt_r == CNT_LAST) begin
            cnt_r <= {CNT_W{1'b0}};
        end else begin
            cnt_r <= cnt_r + CNT_W'(1);
        end
    end

    assign tick     = enable && (cnt_r == CNT_LAST);
    assign pre_tick = enable && (cnt_r == CNT_PRE);

endmodule

// File: rtl/coded_nibble_tx.sv
// Serial framer for coded nibbles: start bit, LSB-first data, optional even
// parity (enabled by defining CODE_TX_PARITY_EN), then stop bit(s); idle high.
module coded_nibble_tx
    import code_link_pkg::*;
#(
    parameter int DATA_W       = CODE_W,
    parameter int CLKS_PER_BIT = 4,
    parameter int STOP_BITS    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              tx_out,
    output logic              busy,
    output logic              frame_done
);

    localparam logic [2:0] S_IDLE   = IDLE;
    localparam logic [2:0] S_START  = START;
    localparam logic [2:0] S_DATA   = DATA;
`ifdef CODE_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = PARITY;
`endif
    localparam logic [2:0] S_STOP   = STOP;

    localparam int BIT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_W - 1);
    localparam logic             STOP_LAST = (STOP_BITS == 2) ? 1'b1 : 1'b0;

    function automatic logic even_parity(input logic [DATA_W-1:0] d);
        return ^d;
    endfunction

    logic [2:0]        state_r;
    logic [DATA_W-1:0] shift_r;
    logic [BIT_W-1:0]  bit_cnt_r;
    logic              stop_cnt_r;
    logic              tx_r;
    logic              busy_r;
    logic              ready_r;
    logic              done_r;
`ifdef CODE_TX_PARITY_EN
    logic              parity_r;
`endif
    logic              tick_s;
    logic              pre_tick_s;
    logic              capture_s;

    assign capture_s = in_valid && ready_r;

    baud_tick_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .reset    (reset),
        .enable   (busy_r),
        .tick     (tick_s),
        .pre_tick (pre_tick_s)
    );

    // Frame sequencer; the line level is registered one bit ahead of each state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r    <= S_IDLE;
            shift_r    <= {DATA_W{1'b0}};
            bit_cnt_r  <= {BIT_W{1'b0}};
            stop_cnt_r <= 1'b0;
            tx_r       <= LINE_IDLE;
            busy_r     <= 1'b0;
            ready_r    <= 1'b1;
            done_r     <= 1'b0;
`ifdef CODE_TX_PARITY_EN
            parity_r   <= 1'b0;
`endif
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (capture_s) begin
                        state_r    <= S_START;
                        shift_r    <= in_data;
                        bit_cnt_r  <= {BIT_W{1'b0}};
                        stop_cnt_r <= 1'b0;
                        tx_r       <= LINE_START;
                        busy_r     <= 1'b1;
                        ready_r    <= 1'b0;
`ifdef CODE_TX_PARITY_EN
                        parity_r   <= even_parity(in_data);
`endif
                    end else begin
                        tx_r <= LINE_IDLE;
                    end
                end
                S_START: begin
                    if (tick_s) begin
                        state_r <= S_DATA;
                        tx_r    <= shift_r[0];
                        shift_r <= shift_r >> 1;
                    end
                end
                S_DATA: begin
                    if (tick_s) begin
                        if (bit_cnt_r == BIT_LAST) begin
`ifdef CODE_TX_PARITY_EN
                            state_r <= S_PARITY;
                            tx_r    <= parity_r;
`else
                            state_r <= S_STOP;
                            tx_r    <= LINE_IDLE;
`endif
                        end else begin
                            bit_cnt_r <= bit_cnt_r + BIT_W'(1);
                            tx_r      <= shift_r[0];
                            shift_r   <= shift_r >> 1;
                        end
                    end
                end
`ifdef CODE_TX_PARITY_EN
                S_PARITY: begin
                    if (tick_s) begin
                        state_r <= S_STOP;
                        tx_r    <= LINE_IDLE;
                    end
                end
`endif
                S_STOP: begin
                    // Raise frame_done one cycle early so it lands on the final stop cycle
                    if (pre_tick_s && (stop_cnt_r == STOP_LAST)) begin
                        done_r <= 1'b1;
                    end
                    if (tick_s) begin
                        if (stop_cnt_r == STOP_LAST) begin
                            state_r <= S_IDLE;
                            busy_r  <= 1'b0;
                            ready_r <= 1'b1;
                        end else begin
                            stop_cnt_r <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    tx_r    <= LINE_IDLE;
                    busy_r  <= 1'b0;
                    ready_r <= 1'b1;
                end
            endcase
        end
    end

    assign tx_out     = tx_r;
    assign busy       = busy_r;
    assign in_ready   = ready_r;
    assign frame_done = done_r;

endmodule

// File: tb/tb_coded_nibble_tx.sv
// Self-checking bench for coded_nibble_tx: a per-cycle line-level queue model
// plus directed boundary cases and a randomized traffic phase.
`timescale 1ns/1ps
module tb_coded_nibble_tx;
    import code_link_pkg::*;

    localparam int CPB = 4;
    localparam int SB  = 1;
    localparam int DW  = CODE_W;
`ifdef CODE_TX_PARITY_EN
    localparam int P = 1;
    localparam int LIT_FL = 28;
    localparam logic [6:0] T2_BITS = 7'b1110110;
`else
    localparam int P = 0;
    localparam int LIT_FL = 24;
    localparam logic [6:0] T2_BITS = 7'b0110110;
`endif
    localparam int FL = frame_len(DW, CPB, SB, P);

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] in_data = 4'd0;
    logic       in_valid = 1'b0;
    logic       in_ready, tx_out, busy, frame_done;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_done = 0;
    bit q[$];
    int cap_q[$];

    always #5 clk = ~clk;

    coded_nibble_tx #(.DATA_W(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
        .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .tx_out(tx_out), .busy(busy), .frame_done(frame_done)
    );

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // One frame as a list of per-cycle line levels
    task automatic push_frame(input logic [3:0] d);
        for (int c = 0; c < CPB; c++) q.push_back(1'b0);
        for (int b = 0; b < DW; b++)
            for (int c = 0; c < CPB; c++) q.push_back(d[b]);
        if (P == 1)
            for (int c = 0; c < CPB; c++) q.push_back(^d);
        for (int c = 0; c < SB * CPB; c++) q.push_back(1'b1);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: consume one level per cycle, accept a word only when empty
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
        end else if (q.size() > 0) begin
            q.delete(0);
        end else if (in_valid) begin
            push_frame(in_data);
            cap_q.push_back(cyc);
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        logic e;
        if (!reset) begin
            e = (q.size() > 0) ? q[0] : 1'b1;
            check1("tx_out", tx_out, e);
            check1("busy", busy, q.size() > 0);
            check1("in_ready", in_ready, q.size() == 0);
            check1("frame_done", frame_done, q.size() == 1);
            if (frame_done) n_done++;
        end
    end

    task automatic send(input logic [3:0] d);
        bit ok;
        ok = 1'b0;
        in_data = d;
        in_valid = 1'b1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        in_valid = 1'b0;
        in_data = 4'($urandom);
        check_int("send_accepted", int'(ok), 1);
    endtask

    task automatic wait_frame_done(output int at);
        at = -1;
        for (int i = 0; i < FL + 50; i++) begin
            @(negedge clk);
            if (frame_done) begin
                at = cyc;
                break;
            end
        end
        check_int("frame_done_seen", int'(at >= 0), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        bit tx_log[$], busy_log[$], ready_log[$], done_log[$];
        logic [6:0] t2_bits;
        int c0, at, nc, d0, bsum;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check1("rst_tx", tx_out, 1'b1);

        // 1: quiet idle after reset
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check1("t1_tx", tx_out, 1'b1);
            check1("t1_ready", in_ready, 1'b1);
            check1("t1_busy", busy, 1'b0);
            check1("t1_done", frame_done, 1'b0);
        end

        // 2: single frame 1011, hand-computed bit levels
        send(4'b1011);
        c0 = cap_q[$];
        for (int k = 1; k <= FL + 1; k++) begin
            @(negedge clk);
            tx_log.push_back(tx_out);
            busy_log.push_back(busy);
            ready_log.push_back(in_ready);
            done_log.push_back(frame_done);
        end
        t2_bits = T2_BITS;
        for (int i = 0; i < FL / CPB; i++)
            check1($sformatf("t2_bit%0d", i), tx_log[i * CPB + 1], t2_bits[i]);
        bsum = 0;
        foreach (busy_log[i]) bsum += int'(busy_log[i]);
        check_int("t2_busy_cycles", bsum, LIT_FL);
        check1("t2_ready_during", ready_log[0], 1'b0);
        check1("t2_done_last", done_log[LIT_FL - 1], 1'b1);
        check1("t2_done_early", done_log[LIT_FL - 2], 1'b0);
        check1("t2_ready_after", ready_log[LIT_FL], 1'b1);

        // 3: in_valid held high across two words
        @(posedge clk);
        #1;
        nc = cap_q.size();
        in_data = 4'b0000;
        in_valid = 1'b1;
        for (int i = 0; i < 4 * FL; i++) begin
            @(posedge clk);
            #1;
            if (cap_q.size() == nc + 1) in_data = 4'b1111;
            if (cap_q.size() == nc + 2) break;
        end
        in_valid = 1'b0;
        check_int("t3_captures", cap_q.size(), nc + 2);
        if (cap_q.size() == nc + 2)
            check_int("t3_spacing", cap_q[nc + 1] - cap_q[nc], LIT_FL + 1);
        repeat (FL + 5) @(posedge clk);
        #1;
        check_int("t3_no_extra", cap_q.size(), nc + 2);

        // 4: reset during the second data bit, then a clean frame
        send(4'b0110);
        repeat (10) @(negedge clk);
        d0 = n_done;
        #1 reset = 1'b1;
        #1;
        check1("t4_tx_async", tx_out, 1'b1);
        check1("t4_busy_async", busy, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check1("t4_ready", in_ready, 1'b1);
        check1("t4_done", frame_done, 1'b0);
        check_int("t4_no_done_pulse", n_done, d0);
        send(4'b0001);
        c0 = cap_q[$];
        wait_frame_done(at);
        check_int("t4_frame_len", at - c0, LIT_FL);

        // 6: in_valid pulse while busy is ignored
        send(4'b1011);
        c0 = cap_q[$];
        nc = cap_q.size();
        repeat (8) @(negedge clk);
        @(posedge clk);
        #1;
        in_data = 4'b0101;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_frame_done(at);
        check_int("t6_frame_len", at - c0, LIT_FL);
        repeat (FL + 5) @(negedge clk);
        check_int("t6_no_extra", cap_q.size(), nc);
        check1("t6_idle", busy, 1'b0);

        // Randomized traffic, including valid pulses while busy
        nc = cap_q.size();
        for (int i = 0; i < 2000; i++) begin
            @(posedge clk);
            #1;
            in_valid = ($urandom_range(0, 3) == 0);
            in_data = 4'($urandom);
        end
        in_valid = 1'b0;
        repeat (FL + 5) @(posedge clk);
        #1;
        check_int("rand_enough_frames", int'(cap_q.size() - nc > 20), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
